// File: rtl/dot_scan_controller.sv
// Row-scanning sequencer for the flip-dot array: holds the frame buffer and walks
// the rows, driving the shared column bus with a coil pulse and dead time per row.
module dot_scan_controller #(
   parameter int COLS  = 16,
   parameter int ROWS  = 8,
   parameter int ROW_W = 3,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [CNT_W-1:0] cfg_pulse_len,
   input  logic [CNT_W-1:0] cfg_dead_len,
   input  logic             cfg_invert,
   input  logic             wr_en,
   input  logic [ROW_W-1:0] wr_row,
   input  logic [COLS-1:0]  wr_data,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             frame_done,
   output logic [ROWS-1:0]  row_sel,
   output logic [COLS-1:0]  dot_enable,
   output logic [COLS-1:0]  dot_state,
   output logic             dot_invert,
   output logic             output_enable
);

   typedef enum logic [2:0] {IDLE, SETUP, PULSE, DEAD, DONE} state_t;

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
   localparam logic [ROWS-1:0]  ROW_ONE  = ROWS'(1);

   state_t           state;
   logic [ROW_W-1:0] row;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] pulse_len;
   logic [CNT_W-1:0] dead_len;
   logic             invert;
   logic [COLS-1:0]  buffer [ROWS];
   logic             write_ok;

   // The buffer is only writable while the registered busy flag is low.
   assign write_ok = wr_en && !busy && (int'(wr_row) < ROWS);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ROWS; i++) buffer[i] <= '0;
      end else if (write_ok) begin
         buffer[wr_row] <= wr_data;
      end
   end

   // Outputs are registered from the current state, so they trail the state by one edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         row           <= '0;
         cnt           <= '0;
         pulse_len     <= '0;
         dead_len      <= '0;
         invert        <= 1'b0;
         busy          <= 1'b0;
         frame_done    <= 1'b0;
         row_sel       <= '0;
         dot_enable    <= '0;
         dot_state     <= '0;
         dot_invert    <= 1'b0;
         output_enable <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         busy       <= (state != IDLE);
         if (abort && state != IDLE) begin
            state         <= IDLE;
            busy          <= 1'b0;
            row_sel       <= '0;
            dot_enable    <= '0;
            dot_state     <= '0;
            dot_invert    <= 1'b0;
            output_enable <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  row_sel       <= '0;
                  dot_enable    <= '0;
                  dot_state     <= '0;
                  dot_invert    <= 1'b0;
                  output_enable <= 1'b0;
                  if (start) begin
                     pulse_len <= cfg_pulse_len;
                     dead_len  <= cfg_dead_len;
                     invert    <= cfg_invert;
                     row       <= '0;
                     state     <= SETUP;
                  end
               end
               SETUP: begin
                  row_sel       <= ROW_ONE << row;
                  dot_state     <= buffer[row];
                  dot_enable    <= '1;
                  dot_invert    <= invert;
                  output_enable <= 1'b0;
                  cnt           <= (pulse_len == '0) ? '0 : pulse_len - 1'b1;
                  state         <= PULSE;
               end
               PULSE: begin
                  output_enable <= 1'b1;
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else if (dead_len != '0) begin
                     cnt   <= dead_len - 1'b1;
                     state <= DEAD;
                  end else if (row == LAST_ROW) begin
                     state <= DONE;
                  end else begin
                     row   <= row + 1'b1;
                     state <= SETUP;
                  end
               end
               DEAD: begin
                  output_enable <= 1'b0;
                  dot_enable    <= '0;
                  row_sel       <= '0;
                  if (cnt != '0) begin
                     cnt <= cnt - 1'b1;
                  end else if (row == LAST_ROW) begin
                     state <= DONE;
                  end else begin
                     row   <= row + 1'b1;
                     state <= SETUP;
                  end
               end
               DONE: begin
                  frame_done    <= 1'b1;
                  row_sel       <= '0;
                  dot_enable    <= '0;
                  dot_state     <= '0;
                  dot_invert    <= 1'b0;
                  output_enable <= 1'b0;
                  state         <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
